svm_pwm_capture: RTL and testbench

// - Receive-side counterpart of the SVM PWM generator. Measures the high time of pwmA/B/C inside each

---
 rtl/svm_pwm_capture_pkg.sv | 25 ++
 rtl/svm_pwm_capture_div.sv | 86 ++++++++
 rtl/svm_pwm_capture.sv | 203 ++++++++++++++++++++
 tb/tb_svm_pwm_capture.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/svm_pwm_capture_pkg.sv
// Shared types and helpers for the SVM PWM capture block.
// - cap_state_t : window capture FSM (waiting for halt fall / counting)
// - div_state_t : per-phase divide sequencer
// - q_max()     : full-scale Q1.(w-1) duty value, 2^(w-1)-1
package svm_pwm_capture_pkg;

  localparam int D_WIDTH_DEFAULT = 16;

  typedef enum logic {
    WAIT_LOW = 1'b0,
    CAPTURE  = 1'b1
  } cap_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV_A = 2'd1,
    DIV_B = 2'd2,
    DIV_C = 2'd3
  } div_state_t;

  function automatic longint unsigned q_max(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

endpackage

// File: rtl/svm_pwm_capture_div.sv
// Sequential unsigned restoring divider, W quotient bits in W clocks.
// The first iteration runs on the start edge, so a result is ready W
// edges after start and done pulses for one cycle with quo valid.
// Precondition: num[2W-1:W] < den (the quotient fits in W bits).
// Ports:
//   clk, rstb        clock, async active-low reset
//   start            load operands (ignored while busy)
//   num [2W-1:0]     dividend
//   den [W:0]        divisor, non-zero
//   busy             iterations in progress
//   done             one-cycle pulse, quo holds the result
//   quo [W-1:0]      quotient
module svm_pwm_capture_div #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rstb,
  input  logic           start,
  input  logic [2*W-1:0] num,
  input  logic [W:0]     den,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   quo
);

  localparam int CW = $clog2(W);

  logic [W:0]    rem_q, rem_in, rem_nx;
  logic [W-1:0]  lo_q, lo_in, lo_nx;
  logic [W-1:0]  quo_q, quo_in, quo_nx;
  logic [CW-1:0] cnt_q;
  logic          busy_q, done_q;
  logic [W+1:0]  trial;
  logic          go, step, qbit;

  assign go   = start && !busy_q;
  assign step = go || busy_q;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor when it fits.
  always_comb begin
    rem_in = go ? {1'b0, num[2*W-1:W]} : rem_q;
    lo_in  = go ? num[W-1:0] : lo_q;
    quo_in = go ? '0 : quo_q;
    trial  = {rem_in, lo_in[W-1]};
    qbit   = (trial >= {1'b0, den});
    rem_nx = qbit ? (trial[W:0] - den) : trial[W:0];
    lo_nx  = {lo_in[W-2:0], 1'b0};
    quo_nx = {quo_in[W-2:0], qbit};
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rem_q  <= '0;
      lo_q   <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      if (step) begin
        rem_q <= rem_nx;
        lo_q  <= lo_nx;
        quo_q <= quo_nx;
      end
      if (go) begin
        cnt_q  <= CW'(W - 1);
        busy_q <= 1'b1;
        done_q <= 1'b0;
      end else if (busy_q) begin
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end else begin
        done_q <= 1'b0;
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign quo  = quo_q;

endmodule

// File: rtl/svm_pwm_capture.sv
// Measures pwmA/B/C high time inside each halt-low window and reports a
// Q1.(D_WIDTH-1) duty word per phase plus the window length.
// Ports:
//   clk, rstb           clock, async active-low reset
//   pwmA/B/C, halt      asynchronous inputs, synchronised internally
//   dA/dB/dC            duty results (saturated to q_max)
//   period              halt-low cycle count of the reported window
//   out_valid/out_ready result handshake
//   overrun             sticky: a completed window was dropped
//   timeout             sticky: halt stayed low too long
//   dbg_state           {cap_state, div_state, divider busy}
//
// Handshake: a result transfers on a posedge with out_valid & out_ready.
// out_valid stays high and dA/dB/dC/period stay constant until then;
// out_valid does not depend on out_ready.
module svm_pwm_capture
  import svm_pwm_capture_pkg::*;
#(
  parameter int D_WIDTH     = D_WIDTH_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               pwmA,
  input  logic               pwmB,
  input  logic               pwmC,
  input  logic               halt,
  output logic [D_WIDTH-1:0] dA,
  output logic [D_WIDTH-1:0] dB,
  output logic [D_WIDTH-1:0] dC,
  output logic [D_WIDTH:0]   period,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               overrun,
  output logic               timeout,
  output logic [3:0]         dbg_state
);

  localparam int                 PW       = D_WIDTH + 1;
  localparam logic [PW-1:0]      PER_LAST = {PW{1'b1}} - 1'b1;
  localparam logic [D_WIDTH-1:0] Q_MAX    = D_WIDTH'(q_max(D_WIDTH));

  function automatic logic [D_WIDTH-1:0] sat_q(input logic [D_WIDTH-1:0] q);
    return (q > Q_MAX) ? Q_MAX : q;
  endfunction

  // Synchronisers: bit 3 = halt, bits 2:0 = pwmC/B/A, all with equal delay
  // so the counted pwm samples line up with the counted halt-low cycles.
  logic [3:0] sync_q [SYNC_STAGES];
  logic       hs, hs_d, fall, rise;
  logic [2:0] pwm_s;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      hs_d <= 1'b0;
    end else begin
      sync_q[0] <= {halt, pwmC, pwmB, pwmA};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      hs_d <= hs;
    end
  end

  assign hs    = sync_q[SYNC_STAGES-1][3];
  assign pwm_s = sync_q[SYNC_STAGES-1][2:0];
  assign fall  = !hs && hs_d;
  assign rise  = hs && !hs_d;

  cap_state_t    cap_state, cap_next;
  div_state_t    div_state, div_next;
  logic [PW-1:0] per_cnt;
  logic [PW-1:0] hi_cnt [3];
  logic          to_hit, cnt_start, cnt_inc, win_close, win_take, to_fire;
  logic          div_start, div_busy, div_done, out_load;
  logic [PW-1:0] num_hi, div_den;
  logic [D_WIDTH-1:0] div_quo, q_a, q_b;
  logic [PW-1:0] sh_hi_b, sh_hi_c, sh_per;

  // Counting the next low cycle would make per_cnt reach all-ones.
  assign to_hit = !hs && (per_cnt == PER_LAST);

  // Capture FSM: state register / next state / outputs.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) cap_state <= WAIT_LOW;
    else       cap_state <= cap_next;
  end

  always_comb begin
    cap_next = cap_state;
    case (cap_state)
      WAIT_LOW: if (fall) cap_next = CAPTURE;
      CAPTURE:  if (rise || to_hit) cap_next = WAIT_LOW;
      default:  cap_next = WAIT_LOW;
    endcase
  end

  // The falling-edge cycle is itself the first low cycle, so it is counted.
  always_comb begin
    cnt_start = (cap_state == WAIT_LOW) && fall;
    cnt_inc   = (cap_state == CAPTURE) && !hs && !to_hit;
    win_close = (cap_state == CAPTURE) && rise;
    to_fire   = (cap_state == CAPTURE) && to_hit;
    // Acceptance is judged before any same-cycle handshake accept.
    win_take  = win_close && (div_state == IDLE) && !out_valid;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      per_cnt <= '0;
      for (int i = 0; i < 3; i++) hi_cnt[i] <= '0;
    end else if (cnt_start) begin
      per_cnt <= PW'(1);
      for (int i = 0; i < 3; i++) hi_cnt[i] <= PW'(pwm_s[i]);
    end else if (cnt_inc) begin
      per_cnt <= per_cnt + 1'b1;
      for (int i = 0; i < 3; i++) hi_cnt[i] <= hi_cnt[i] + PW'(pwm_s[i]);
    end else begin
      per_cnt <= '0;
      for (int i = 0; i < 3; i++) hi_cnt[i] <= '0;
    end
  end

  // Divide sequencer: state register / next state / outputs.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) div_state <= IDLE;
    else       div_state <= div_next;
  end

  always_comb begin
    div_next = div_state;
    case (div_state)
      IDLE:    if (win_take) div_next = DIV_A;
      DIV_A:   if (div_done) div_next = DIV_B;
      DIV_B:   if (div_done) div_next = DIV_C;
      DIV_C:   if (div_done) div_next = IDLE;
      default: div_next = IDLE;
    endcase
  end

  // Phase A starts straight from the live counters on the closing edge;
  // B and C come from the shadow copies taken on that same edge.
  always_comb begin
    div_start = win_take ||
                (div_done && ((div_state == DIV_A) || (div_state == DIV_B)));
    out_load  = div_done && (div_state == DIV_C);
    case (div_state)
      IDLE:    num_hi = hi_cnt[0];
      DIV_A:   num_hi = sh_hi_b;
      default: num_hi = sh_hi_c;
    endcase
    div_den = (div_state == IDLE) ? per_cnt : sh_per;
  end

  svm_pwm_capture_div #(.W(D_WIDTH)) u_div (
    .clk   (clk),
    .rstb  (rstb),
    .start (div_start),
    .num   ({num_hi, {(D_WIDTH-1){1'b0}}}),
    .den   (div_den),
    .busy  (div_busy),
    .done  (div_done),
    .quo   (div_quo)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sh_hi_b   <= '0;
      sh_hi_c   <= '0;
      sh_per    <= '0;
      q_a       <= '0;
      q_b       <= '0;
      dA        <= '0;
      dB        <= '0;
      dC        <= '0;
      period    <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      if (win_take) begin
        sh_hi_b <= hi_cnt[1];
        sh_hi_c <= hi_cnt[2];
        sh_per  <= per_cnt;
      end
      if (div_done && (div_state == DIV_A)) q_a <= div_quo;
      if (div_done && (div_state == DIV_B)) q_b <= div_quo;
      if (out_load) begin
        dA        <= sat_q(q_a);
        dB        <= sat_q(q_b);
        dC        <= sat_q(div_quo);
        period    <= sh_per;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (win_close && !win_take) overrun <= 1'b1;
      if (to_fire)                timeout <= 1'b1;
    end
  end

  assign dbg_state = {cap_state, div_state, div_busy};

endmodule

// File: tb/tb_svm_pwm_capture.sv
module tb_svm_pwm_capture;

  localparam int DW  = 16;
  localparam int SS  = 2;
  localparam int DWS = 8;
  localparam int RW  = 3 * DW + DW + 1;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  logic          pwmA = 0, pwmB = 0, pwmC = 0, halt = 1, out_ready = 1;
  logic [DW-1:0] dA, dB, dC;
  logic [DW:0]   period;
  logic          out_valid, overrun, timeout;
  logic [3:0]    dbg_state;

  logic           pwmA_s = 0, pwmB_s = 0, pwmC_s = 0, halt_s = 1, out_ready_s = 1;
  logic [DWS-1:0] dA_s, dB_s, dC_s;
  logic [DWS:0]   period_s;
  logic           out_valid_s, overrun_s, timeout_s;
  logic [3:0]     dbg_state_s;

  svm_pwm_capture #(.D_WIDTH(DW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rstb(rstb), .pwmA(pwmA), .pwmB(pwmB), .pwmC(pwmC), .halt(halt),
    .dA(dA), .dB(dB), .dC(dC), .period(period), .out_valid(out_valid),
    .out_ready(out_ready), .overrun(overrun), .timeout(timeout), .dbg_state(dbg_state)
  );

  // Narrow instance so the timeout limit (2^(DWS+1)-1) is reachable quickly.
  svm_pwm_capture #(.D_WIDTH(DWS), .SYNC_STAGES(SS)) dut_s (
    .clk(clk), .rstb(rstb), .pwmA(pwmA_s), .pwmB(pwmB_s), .pwmC(pwmC_s), .halt(halt_s),
    .dA(dA_s), .dB(dB_s), .dC(dC_s), .period(period_s), .out_valid(out_valid_s),
    .out_ready(out_ready_s), .overrun(overrun_s), .timeout(timeout_s), .dbg_state(dbg_state_s)
  );

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: duty = high_cycles * 2^(dw-1) / window_cycles, clipped to full scale.
  function automatic longint ref_duty(input int h, input int len, input int dw);
    longint q;
    longint full;
    full = (longint'(1) << (dw - 1)) - 1;
    q = (longint'(h) << (dw - 1)) / longint'(len);
    if (q > full) q = full;
    return q;
  endfunction

  function automatic logic [RW-1:0] ref_word(input int len, input int ha, input int hb, input int hc);
    return {DW'(ref_duty(ha, len, DW)), DW'(ref_duty(hb, len, DW)),
            DW'(ref_duty(hc, len, DW)), (DW+1)'(len)};
  endfunction

  // Monitor: every accepted result is compared against the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (rstb && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_result: got 0x%0h, expected no output (t=%0t)",
                   {dA, dB, dC, period}, $time);
        end else begin
          check("result", {dA, dB, dC, period}, exp_q.pop_front());
        end
      end
    end
  end

  int vs_cnt = 0;
  always @(negedge clk) if (out_valid_s) vs_cnt++;

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Halt low for len cycles with each pwm high for its first hX of them,
  // then halt high for gap cycles with random pwm (which must not count).
  task automatic run_window(input int len, input int ha, input int hb, input int hc,
                            input int gap, input bit expect_out);
    for (int i = 0; i < len; i++) begin
      halt = 1'b0;
      pwmA = (i < ha);
      pwmB = (i < hb);
      pwmC = (i < hc);
      tick(1);
    end
    if (expect_out) exp_q.push_back(ref_word(len, ha, hb, hc));
    for (int i = 0; i < gap; i++) begin
      halt = 1'b1;
      pwmA = 1'($urandom_range(0, 1));
      pwmB = 1'($urandom_range(0, 1));
      pwmC = 1'($urandom_range(0, 1));
      tick(1);
    end
    halt = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      tick(1);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_dA"}, dA, 0);
    check({tag, "_dB"}, dB, 0);
    check({tag, "_dC"}, dC, 0);
    check({tag, "_period"}, period, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_timeout"}, timeout, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat, len, ha, hb, hc, nv;

    // reset state
    tick(3);
    check_cleared("reset");
    rstb = 1'b1;

    // halt held high: nothing happens
    tick(30);
    check("idle_no_valid", out_valid, 0);

    // directed 200-cycle window, latency from pin rise
    run_window(200, 100, 0, 200, 0, 1'b1);
    lat = 0;
    while (!out_valid && lat < 200) begin
      tick(1);
      lat++;
    end
    check("latency", lat, 3 * DW + 1 + SS);
    tick(20);
    drain("drain_directed");

    // one-cycle window
    run_window(1, 1, 0, 1, 70, 1'b1);
    drain("drain_len1");

    // randomized windows, spaced beyond the divider latency
    for (int k = 0; k < 20; k++) begin
      len = $urandom_range(1, 300);
      ha  = $urandom_range(0, len);
      hb  = $urandom_range(0, len);
      hc  = (k % 4 == 0) ? len : $urandom_range(0, len);
      run_window(len, ha, hb, hc, $urandom_range(60, 90), 1'b1);
    end
    drain("drain_random");
    check("random_overrun", overrun, 0);
    check("random_timeout", timeout, 0);

    // back-pressure: second window is dropped, first held
    out_ready = 1'b0;
    run_window(200, 50, 150, 10, 100, 1'b1);
    run_window(200, 200, 0, 100, 100, 1'b0);
    check("ovr_flag", overrun, 1);
    check("ovr_valid_held", out_valid, 1);
    out_ready = 1'b1;
    tick(1);
    check("ovr_valid_after_accept", out_valid, 0);
    check("ovr_sticky", overrun, 1);
    check("ovr_queue", exp_q.size(), 0);

    // reset in the middle of the divide
    rstb = 1'b0;
    tick(3);
    rstb = 1'b1;
    tick(10);
    run_window(150, 75, 30, 120, 10, 1'b0);
    rstb = 1'b0;
    tick(3);
    check_cleared("middiv");
    rstb = 1'b1;
    nv = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (out_valid) nv++;
    end
    check("middiv_no_output", nv, 0);
    run_window(120, 30, 60, 90, 80, 1'b1);
    drain("drain_after_reset");

    // timeout on the narrow instance: halt low forever
    halt_s = 1'b0;
    tick(505);
    check("timeout_early", timeout_s, 0);
    tick(25);
    check("timeout_set", timeout_s, 1);
    check("timeout_no_valid", vs_cnt, 0);
    halt_s = 1'b1;
    tick(10);
    for (int i = 0; i < 100; i++) begin
      halt_s = 1'b0;
      pwmA_s = (i < 50);
      pwmB_s = 1'b0;
      pwmC_s = 1'b1;
      tick(1);
    end
    halt_s = 1'b1;
    pwmA_s = 1'b0;
    pwmC_s = 1'b0;
    nv = 0;
    while (!out_valid_s && nv < 200) begin
      tick(1);
      nv++;
    end
    check("post_timeout_valid", out_valid_s, 1);
    check("post_timeout_dA", dA_s, ref_duty(50, 100, DWS));
    check("post_timeout_dB", dB_s, ref_duty(0, 100, DWS));
    check("post_timeout_dC", dC_s, ref_duty(100, 100, DWS));
    check("post_timeout_period", period_s, 100);
    check("post_timeout_sticky", timeout_s, 1);

    tick(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
